// File: rtl/apwm_encoder.sv
// APWM transmit encoder: turns a duty word into a fixed-period APWM waveform.
// Duty is shadowed at period boundaries; a level fault latches until cleared.
module apwm_encoder #(
    parameter int PERIOD = 1000,
    parameter int DUTY_W = 10
) (
    input  logic              CLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic [DUTY_W-1:0] iDuty,
    input  logic              iFAULT,
    input  logic              iClrFault,
    output logic              oAPWM,
    output logic              oPeriodStart,
    output logic [DUTY_W-1:0] oDutyApplied,
    output logic              oFault,
    output logic              oRun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [DUTY_W-1:0] PERIOD_W = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] LAST_W   = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] ZERO_W   = {DUTY_W{1'b0}};
    localparam logic [DUTY_W-1:0] ONE_W    = {{(DUTY_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [DUTY_W-1:0] cnt_r, cnt_s;
    logic [DUTY_W-1:0] duty_sh_r, duty_sh_s;
    logic [DUTY_W-1:0] dclamp_s, cnt_inc_s;
    logic              apwm_r, apwm_s;
    logic              pstart_r, pstart_s;
    logic              run_r, fault_r;

    // Saturate the requested duty at a full period and precompute the count step.
    always_comb begin
        if (iDuty > PERIOD_W) begin
            dclamp_s = PERIOD_W;
        end else begin
            dclamp_s = iDuty;
        end
        cnt_inc_s = cnt_r + ONE_W;
    end

    // Next-state, counter, shadow-duty and next-output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        duty_sh_s = duty_sh_r;
        apwm_s    = 1'b0;
        pstart_s  = 1'b0;
        if (iFAULT) begin
            // Fault wins over enable and over the period wrap.
            state_s = ST_FAULT;
            cnt_s   = ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = ZERO_W;
                    if (iEN) begin
                        state_s   = ST_RUN;
                        duty_sh_s = dclamp_s;
                        pstart_s  = 1'b1;
                        apwm_s    = (dclamp_s != ZERO_W);
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == LAST_W) begin
                        cnt_s = ZERO_W;
                        if (iEN) begin
                            duty_sh_s = dclamp_s;
                            pstart_s  = 1'b1;
                            apwm_s    = (dclamp_s != ZERO_W);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        cnt_s  = cnt_inc_s;
                        apwm_s = (cnt_inc_s < duty_sh_r);
                    end
                end
                ST_FAULT: begin
                    cnt_s = ZERO_W;
                    if (iClrFault) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FAULT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_W;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (iRST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_W;
            duty_sh_r <= ZERO_W;
            apwm_r    <= 1'b0;
            pstart_r  <= 1'b0;
            run_r     <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            duty_sh_r <= duty_sh_s;
            apwm_r    <= apwm_s;
            pstart_r  <= pstart_s;
            run_r     <= (state_s == ST_RUN);
            fault_r   <= (state_s == ST_FAULT);
        end
    end

    assign oAPWM        = apwm_r;
    assign oPeriodStart = pstart_r;
    assign oDutyApplied = duty_sh_r;
    assign oFault       = fault_r;
    assign oRun         = run_r;

endmodule
